// File: rtl/fpu_pkg.sv
// Shared FPU types and FP32 format constants used across the execute cluster.
package fpu_pkg;
   localparam int FP32_BIAS  = 127;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exp;
      logic [FP32_MAN_W-1:0] man;
   } fp32_t;

   typedef logic [4:0] fpu_tag_t;
endpackage

// File: rtl/itof_pipeline_if.sv
// Issue-side and writeback-side valid/ready handshake of the int-to-float unit.
interface itof_pipeline_if;
   import fpu_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_unsigned;
   fpu_tag_t    in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   fpu_tag_t    out_tag;
   logic        out_inexact;

   modport master (
      output in_valid, in_data, in_unsigned, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_inexact
   );

   modport slave (
      input  in_valid, in_data, in_unsigned, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_inexact
   );
endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; count = 32 for an all-zero value.
module lzc32 (
   input  logic [31:0] value,
   output logic [5:0]  count
);
   function automatic logic [3:0] lzc8(input logic [7:0] v);
      lzc8 = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) lzc8 = 4'(7 - i);
      end
   endfunction

   logic [3:0][3:0] c8;
   logic [4:0]      c16_lo;
   logic [4:0]      c16_hi;

   // Byte counts merge pairwise; bit 3/4 of a partial count flags an all-zero half.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < 4; i++) c8[i] = lzc8(value[8*i +: 8]);
      c16_lo = c8[1][3] ? (5'd8 + {1'b0, c8[0]}) : {1'b0, c8[1]};
      c16_hi = c8[3][3] ? (5'd8 + {1'b0, c8[2]}) : {1'b0, c8[3]};
      count  = c16_hi[4] ? (6'd16 + {1'b0, c16_lo}) : {1'b0, c16_hi};
   end
endmodule

// File: rtl/itof_pipeline.sv
// Two-stage int32/uint32 to FP32 converter (fcvt.s.w / fcvt.s.wu), round-to-nearest-even.
module itof_pipeline
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   itof_pipeline_if.slave    bus
);
   localparam logic [7:0] EXP_BASE = 8'(FP32_BIAS + 31);

   logic        s1_valid;
   logic        s1_sign;
   logic [31:0] s1_abs;
   fpu_tag_t    s1_tag;

   logic        out_valid;
   logic [31:0] out_data;
   fpu_tag_t    out_tag;
   logic        out_inexact;

   logic        s2_adv;
   logic        s1_adv;
   logic        in_sign;
   logic [31:0] in_abs;

   logic [5:0]  lzc;
   logic [31:0] norm;
   logic [7:0]  exp_raw;
   logic [7:0]  exp_rnd;
   logic [23:0] man_sum;
   logic [22:0] man_rnd;
   logic        guard;
   logic        sticky;
   logic        round_up;
   fp32_t       result;

   assign s2_adv       = !out_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv && rst_n;

   assign in_sign = bus.in_data[31] && !bus.in_unsigned;
   assign in_abs  = in_sign ? (~bus.in_data + 32'd1) : bus.in_data;

   lzc32 u_lzc (
      .value (s1_abs),
      .count (lzc)
   );

   // A zero operand is forced to +0 so the biased exponent of 126 never leaks out.
   always_comb begin
      norm     = s1_abs << lzc;
      exp_raw  = EXP_BASE - {2'b00, lzc};
      guard    = norm[7];
      sticky   = |norm[6:0];
      round_up = guard && (sticky || norm[8]);
      man_sum  = {1'b0, norm[30:8]} + {23'd0, round_up};
      exp_rnd  = man_sum[23] ? (exp_raw + 8'd1) : exp_raw;
      man_rnd  = man_sum[23] ? 23'd0 : man_sum[22:0];
      result   = '0;
      if (s1_abs != 32'd0) result = '{sign: s1_sign, exp: exp_rnd, man: man_rnd};
   end

   // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset too, so outputs read as zero during reset.
         s1_valid    <= 1'b0;
         s1_sign     <= 1'b0;
         s1_abs      <= '0;
         s1_tag      <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_tag     <= '0;
         out_inexact <= 1'b0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data    <= result;
               out_tag     <= s1_tag;
               out_inexact <= guard || sticky;
            end
         end
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sign <= in_sign;
               s1_abs  <= in_abs;
               s1_tag  <= bus.in_tag;
            end
         end
      end
   end

   assign bus.out_valid   = out_valid;
   assign bus.out_data    = out_data;
   assign bus.out_tag     = out_tag;
   assign bus.out_inexact = out_inexact;
endmodule

// File: tb/tb_itof_pipeline.sv
// Directed bench for itof_pipeline: vector table plus backpressure, flush and reset sequences.
module tb_itof_pipeline;
   import fpu_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        uns;
      logic [31:0] res;
      logic        nx;
   } vec_t;

   localparam int N_VEC = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   itof_pipeline_if bus ();

   itof_pipeline dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   vec_t        vecs [N_VEC];
   logic [31:0] bp_exp [6];
   bit          bp_pat [6];
   int          accepted;
   int          delivered;
   bit          prev_stall;
   logic [31:0] prev_data;
   fpu_tag_t    prev_tag;
   bit          exp_ready;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h00000001, 1'b0, 32'h3F800000, 1'b0};
      vecs[1]  = '{32'hFFFFFFFF, 1'b0, 32'hBF800000, 1'b0};
      vecs[2]  = '{32'd123,      1'b0, 32'h42F60000, 1'b0};
      vecs[3]  = '{32'hFFFFFF85, 1'b0, 32'hC2F60000, 1'b0};
      vecs[4]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0};
      vecs[5]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1};
      vecs[6]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1};
      vecs[7]  = '{32'h7FFFFFFF, 1'b0, 32'h4F000000, 1'b1};
      vecs[8]  = '{32'h80000000, 1'b0, 32'hCF000000, 1'b0};
      vecs[9]  = '{32'h80000000, 1'b1, 32'h4F000000, 1'b0};
      vecs[10] = '{32'hFFFFFFFF, 1'b1, 32'h4F800000, 1'b1};
      vecs[11] = '{32'hFFFFFFFF, 1'b0, 32'hBF800000, 1'b0};
      bp_exp   = '{32'h3F800000, 32'h40000000, 32'h40400000,
                   32'h40800000, 32'h40A00000, 32'h40C00000};
      bp_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n           = 1'b0;
      flush           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_unsigned = 1'b0;
      bus.in_tag      = '0;
      bus.out_ready   = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_out_data",    bus.out_data,         32'd0);
      check("rst_out_tag",     32'(bus.out_tag),     32'd0);
      check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
      check("rst_in_ready",    32'(bus.in_ready),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

      // Back-to-back vector table, two-edge latency
      for (int c = 0; c < N_VEC + 2; c++) begin
         @(posedge clk); #1;
         if (c >= 2) begin
            check("vec_valid",   32'(bus.out_valid),   32'd1);
            check("vec_data",    bus.out_data,         vecs[c-2].res);
            check("vec_inexact", 32'(bus.out_inexact), 32'(vecs[c-2].nx));
            check("vec_tag",     32'(bus.out_tag),     32'(c - 2));
         end else begin
            check("vec_latency_empty", 32'(bus.out_valid), 32'd0);
         end
         if (c < N_VEC) begin
            bus.in_valid    = 1'b1;
            bus.in_data     = vecs[c].data;
            bus.in_unsigned = vecs[c].uns;
            bus.in_tag      = 5'(c);
         end else begin
            bus.in_valid    = 1'b0;
            bus.in_unsigned = 1'b0;
         end
      end

      // Backpressure stream
      accepted   = 0;
      delivered  = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_tag   = '0;
      for (int c = 0; c < 40 && delivered < 6; c++) begin
         @(posedge clk); #1;
         bus.out_ready = bp_pat[c % 6];
         bus.in_valid  = (accepted < 6);
         bus.in_data   = 32'(accepted + 1);
         bus.in_tag    = 5'(accepted);
         #1;
         if (prev_stall) begin
            check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            check("bp_stall_data",  bus.out_data,       prev_data);
            check("bp_stall_tag",   32'(bus.out_tag),   32'(prev_tag));
         end
         exp_ready = !((accepted - delivered) == 2 && !bus.out_ready);
         check("bp_in_ready", 32'(bus.in_ready), 32'(exp_ready));
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_tag   = bus.out_tag;
         if (bus.out_valid && bus.out_ready) begin
            check("bp_tag",  32'(bus.out_tag), 32'(delivered));
            check("bp_data", bus.out_data,     bp_exp[delivered]);
            delivered++;
         end
         if (bus.in_valid && bus.in_ready) accepted++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_delivered", 32'(delivered), 32'd6);
      @(posedge clk); #1;
      check("bp_no_extra", 32'(bus.out_valid), 32'd0);

      // Flush with two in flight and a third presented
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd1;
      bus.in_tag   = 5'd10;
      @(posedge clk); #1;
      bus.in_data  = 32'd2;
      bus.in_tag   = 5'd11;
      @(posedge clk); #1;
      check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
      bus.in_data  = 32'd3;
      bus.in_tag   = 5'd12;
      flush        = 1'b1;
      @(posedge clk); #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("flush_third_dropped", 32'(bus.out_valid), 32'd0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd123;
      bus.in_tag   = 5'd13;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("post_flush_valid", 32'(bus.out_valid), 32'd1);
      check("post_flush_data",  bus.out_data,       32'h42F60000);
      check("post_flush_tag",   32'(bus.out_tag),   32'd13);

      // Asynchronous reset with both stages full
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'd5;
      bus.in_tag    = 5'd20;
      @(posedge clk); #1;
      bus.in_data   = 32'd6;
      bus.in_tag    = 5'd21;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      check("rst_mid_pre_valid", 32'(bus.out_valid), 32'd1);
      check("rst_mid_pre_tag",   32'(bus.out_tag),   32'd20);
      check("rst_mid_pre_data",  bus.out_data,       32'h40A00000);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_out_data",  bus.out_data,       32'd0);
      check("rst_mid_out_tag",   32'(bus.out_tag),   32'd0);
      check("rst_mid_in_ready",  32'(bus.in_ready),  32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_hold_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_hold_ready", 32'(bus.in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_mid_release_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      check("rst_mid_killed", 32'(bus.out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/itof_pipeline.md
# itof_pipeline

Two-stage pipelined converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision, rounding to nearest, ties to even. It is the integer-to-float counterpart of the FPU's float-rounding units and executes fcvt.s.w / fcvt.s.wu. It sits in the FPU execute cluster between the issue queue and the FP writeback arbiter. A valid/ready handshake on both sides gives it full backpressure.

## Interface
- Parameters: none.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline kill; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  32  integer operand.
- in_unsigned  in  1  1 = treat in_data as unsigned; 0 = two's complement.
- in_tag  in  5  destination register tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  FP32 result.
- out_tag  out  5  tag of the result.
- out_inexact  out  1  result was rounded (NX flag contribution).

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1 register (s1_valid, s1_sign, s1_abs[31:0], s1_tag) captures the operand:
  - sign = in_data[31] && !in_unsigned.
  - abs = sign ? -in_data : in_data, taken as a 32-bit unsigned value. INT_MIN gives abs = 0x80000000.
- Stage 1 combinational logic:
  - lzc = leading zeros of s1_abs (0..32).
  - norm = s1_abs << lzc.
  - exp = 158 - lzc, computed 8 bits wide.
  - man = norm[30:8], guard = norm[7], sticky = |norm[6:0].
  - round_up = guard && (sticky || man[0]).
  - {carry, man'} = man + round_up. If carry is set: exp' = exp + 1 and man' = 0.
- Stage 2 register (output) drives out_data, out_tag and out_inexact:
  - out_data = {sign, exp', man'}.
  - out_inexact = guard || sticky.
- Zero input (lzc = 32) gives 0x00000000 with inexact 0. A negative zero result is never produced.
- Overflow, NaN and denormal outputs cannot occur. The maximum exponent is 159 (2^32).

## Timing
- Latency: a result appears 2 cycles after its input transfer edge, measured with out_ready held high. Throughput is 1 operation per cycle.
- Ready chain (combinational, no skid buffer):
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && rst_n.
- Stall behaviour:
  - While out_valid && !out_ready, out_data, out_tag and out_inexact hold stable.
  - Stage 1 holds its contents if s2_adv = 0.
  - No operation is ever dropped or duplicated.
- Simultaneous transfers: an output transfer and a stage-1 → stage-2 move in the same cycle are legal and keep full rate.
- Flush:
  - On the clock edge where flush = 1, s1_valid and out_valid clear.
  - An input presented in the same cycle is discarded, because flush wins over acceptance.
  - Data registers may keep stale values.
- Reset values: out_valid 0, out_data 0x00000000, out_tag 0, out_inexact 0, s1_valid 0, and all internal data registers 0.
- Reset mid-operation:
  - Asserting rst_n kills in-flight operations immediately.
  - in_ready is 0 while rst_n = 0.
  - in_ready is 1 on the first cycle after release.

## Structure
- Shared package fpu_pkg holds:
  - FP32 constants: FP32_BIAS = 127, FP32_EXP_W = 8, FP32_MAN_W = 23.
  - typedef fp32_t: packed struct {sign, exp[7:0], man[22:0]}.
  - typedef fpu_tag_t (5-bit register tag).
- One sub-module, lzc32: a combinational 32-bit leading-zero counter with a 6-bit count output (32 for all-zero). It is implemented as a tree and is reusable by the float-to-int path.

## Test plan
- Basic values, back-to-back with out_ready = 1:
  - 1 → 0x3F800000.
  - -1 (signed) → 0xBF800000.
  - 123 → 0x42F60000.
  - -123 → 0xC2F60000.
  - 0 → 0x00000000.
  - Each result appears 2 cycles after its input; inexact = 0 for all.
- Rounding:
  - 0x01000001 → 0x4B800000 (tie, round to even, down), inexact 1.
  - 0x01000003 → 0x4B800002 (tie, round up), inexact 1.
  - 0x7FFFFFFF → 0x4F000000 (mantissa carry into exponent), inexact 1.
- Extremes:
  - 0x80000000 signed → 0xCF000000, inexact 0.
  - 0x80000000 unsigned → 0x4F000000.
  - 0xFFFFFFFF unsigned → 0x4F800000, inexact 1.
  - 0xFFFFFFFF signed → 0xBF800000.
- Backpressure:
  - Stream 6 operands with tags 0..5 while out_ready follows a 1,0,0,1,1,0… pattern.
  - Outputs arrive in order with the correct tags and no loss.
  - out_data is stable during stalls.
  - in_ready is 0 only when both stages are full and out_ready = 0.
- Flush: with 2 operations in flight and a third presented, pulse flush for one cycle. Required response:
  - out_valid is 0 the next cycle.
  - The third operation never appears.
  - The next input after the flush completes normally.
- Reset mid-stream: assert rst_n low asynchronously (between clock edges) while both stages are valid. Required response:
  - out_valid, out_data and out_tag go to 0 immediately.
  - in_ready is 0 during reset and 1 on the first cycle after release.
